// File: rtl/radix2_stage_sequencer.sv
// rtl/radix2_stage_sequencer.sv - in-place radix-2 DIT FFT stage/butterfly address sequencer
module radix2_stage_sequencer #(
  parameter int N_LOG2   = 4,
  parameter int PIPE_LAT = 3,
  localparam int SW      = $clog2(N_LOG2 + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bf_valid,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr1,
  output logic [N_LOG2-1:0] rd_addr2,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bf_en,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr1,
  output logic [N_LOG2-1:0] wr_addr2,
  output logic [SW-1:0]     stage,
  output logic              lat_err
);

  localparam int CW = N_LOG2 - 1;
  localparam int IW = $clog2(PIPE_LAT + 2);
  localparam logic [CW-1:0] LAST_BF = {CW{1'b1}};
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     bf_cnt;
  logic [IW-1:0]     inflight;
  logic [IW-1:0]     inflight_now;
  logic              start_acc;
  logic              stage_adv;
  logic              issuing;
  logic [PIPE_LAT-1:0] v_pipe;
  logic [N_LOG2-1:0] a1_pipe [PIPE_LAT];
  logic [N_LOG2-1:0] a2_pipe [PIPE_LAT];
  logic [N_LOG2-1:0] cnt_ext, span, pos, grp, base1, tw_full;

  assign issuing  = (state == S_ISSUE);
  assign busy     = (state == S_ISSUE) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign bf_en    = v_pipe[0];
  assign wr_en    = v_pipe[PIPE_LAT-1];
  assign wr_addr1 = a1_pipe[PIPE_LAT-1];
  assign wr_addr2 = a2_pipe[PIPE_LAT-1];

  // Outstanding butterflies once the write leaving the pipe this cycle is counted as done.
  assign inflight_now = inflight - IW'(wr_en);

  // Butterfly address pair and twiddle index for the current stage and count; zero when idle.
  always_comb begin
    cnt_ext  = N_LOG2'(bf_cnt);
    span     = N_LOG2'(1) << stage;
    pos      = cnt_ext & (span - N_LOG2'(1));
    grp      = cnt_ext >> stage;
    base1    = (grp << (stage + SW'(1))) | pos;
    tw_full  = pos << (LAST_STAGE - stage);
    rd_en    = issuing;
    rd_addr1 = issuing ? base1 : '0;
    rd_addr2 = issuing ? (base1 + span) : '0;
    tw_addr  = issuing ? tw_full[N_LOG2-2:0] : '0;
  end

  // Next-state logic; DONE also samples start so a held start restarts without a dead cycle.
  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    stage_adv = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n   = S_ISSUE;
          start_acc = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bf_cnt == LAST_BF) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight_now == '0) begin
          if (stage == LAST_STAGE) begin
            state_n = S_DONE;
          end else begin
            state_n   = S_ISSUE;
            stage_adv = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_n   = S_ISSUE;
          start_acc = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, butterfly counter, stage index and in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bf_cnt   <= '0;
      stage    <= '0;
      inflight <= '0;
    end else begin
      state    <= state_n;
      inflight <= inflight + IW'(rd_en) - IW'(wr_en);
      if (start_acc || stage_adv) bf_cnt <= '0;
      else if (issuing)           bf_cnt <= bf_cnt + CW'(1);
      if (start_acc)      stage <= '0;
      else if (stage_adv) stage <= stage + SW'(1);
    end
  end

  // Write-back delay line carrying the read strobe and address pair to the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        a1_pipe[i] <= '0;
        a2_pipe[i] <= '0;
      end
    end else begin
      v_pipe     <= {v_pipe[PIPE_LAT-2:0], rd_en};
      a1_pipe[0] <= rd_addr1;
      a2_pipe[0] <= rd_addr2;
      for (int i = 1; i < PIPE_LAT; i++) begin
        a1_pipe[i] <= a1_pipe[i-1];
        a2_pipe[i] <= a2_pipe[i-1];
      end
    end
  end

  // Sticky latency error: butterfly valid must track the expected write tap exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                lat_err <= 1'b0;
    else if (start_acc)        lat_err <= 1'b0;
    else if (bf_valid != wr_en) lat_err <= 1'b1;
  end

endmodule
